// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states,
// counter sizing and op classification. MD_ACCUMULATE_EN enables MADD/MADDU/MSUB/MSUBU.
package md_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MFHI  = 4'd4,
        MFLO  = 4'd5,
        MTHI  = 4'd6,
        MTLO  = 4'd7,
        MADD  = 4'd8,
        MADDU = 4'd9,
        MSUB  = 4'd10,
        MSUBU = 4'd11,
        NOP   = 4'd15
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
        return $clog2(((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1);
    endfunction

    function automatic logic md_is_start_op(input logic [3:0] op);
        case (op)
            MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MD_ACCUMULATE_EN
            MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product / quotient-remainder datapath returning {hi_next, lo_next}.
// res_ok is low when the result must not be committed (divide by zero, invalid op).
module md_arith
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MD_ACCUMULATE_EN
    input  logic [2*WIDTH-1:0] acc,
`endif
    output logic [2*WIDTH-1:0] res,
    output logic               res_ok
);

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   mag_q;
    logic [WIDTH-1:0]   mag_r;
    logic [WIDTH-1:0]   s_quo;
    logic [WIDTH-1:0]   s_rem;

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide via magnitudes; MIN / -1 wraps naturally to quotient MIN, remainder 0.
    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;
    assign mag_q = a_mag / b_mag;
    assign mag_r = a_mag % b_mag;
    assign s_quo = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
    assign s_rem = a_neg ? (~mag_r + 1'b1) : mag_r;

    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        case (op)
            MULT:  res = prod_s;
            MULTU: res = prod_u;
            DIV: begin
                res    = {s_rem, s_quo};
                res_ok = |b;
            end
            DIVU: begin
                res    = {a % b, a / b};
                res_ok = |b;
            end
`ifdef MD_ACCUMULATE_EN
            MADD:  res = acc + prod_s;
            MADDU: res = acc + prod_u;
            MSUB:  res = acc - prod_s;
            MSUBU: res = acc - prod_u;
`endif
            default: res_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: result is computed at issue and held pending until the
// busy countdown expires. MD_ACCUMULATE_EN adds the MADD/MSUB family.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_out
);

    localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   pend_q, pend_d;
    logic                 pend_ok_q, pend_ok_d;
    logic [2*WIDTH-1:0]   arith_res;
    logic                 arith_ok;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
`ifdef MD_ACCUMULATE_EN
        .acc    ({hi_q, lo_q}),
`endif
        .res    (arith_res),
        .res_ok (arith_ok)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_ok_d = pend_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (!cancel) begin
                    if (start && md_is_start_op(op)) begin
                        pend_d    = arith_res;
                        pend_ok_d = arith_ok;
                        cnt_d     = md_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_d   = ST_RUN;
                    end else if (op == MTHI) begin
                        hi_d = a;
                    end else if (op == MTLO) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // A zero count here is unreachable; treat it as expiry so the unit cannot hang.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (pend_ok_q) begin
                        {hi_d, lo_d} = pend_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        md_out = '0;
        if (op == MFHI) md_out = hi_q;
        else if (op == MFLO) md_out = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy length are queued at issue
// and checked when busy drops; direct checks cover MTHI/MTLO, cancel, reset and md_out.
module tb_mult_div_unit;
    import md_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cycles;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cancel;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] md_out;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .cancel  (cancel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .md_out  (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour written with 64-bit host arithmetic (SV / and % truncate toward zero).
    function automatic logic [63:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic [W-1:0] h,
                                          input logic [W-1:0] l);
        longint       sx, sy, q, r;
        logic [63:0]  res;
        res = {h, l};
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        case (o)
            MULT:  res = 64'(sx * sy);
            MULTU: res = {32'b0, x} * {32'b0, y};
            DIV: if (y != 0) begin
                q   = sx / sy;
                r   = sx % sy;
                res = {r[31:0], q[31:0]};
            end
            DIVU: if (y != 0) res = {x % y, x / y};
`ifdef MD_ACCUMULATE_EN
            MADD:  res = {h, l} + 64'(sx * sy);
            MADDU: res = {h, l} + {32'b0, x} * {32'b0, y};
            MSUB:  res = {h, l} - 64'(sx * sy);
            MSUBU: res = {h, l} - {32'b0, x} * {32'b0, y};
`endif
            default: res = {h, l};
        endcase
        return res;
    endfunction

    task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input int ecyc);
        exp_t e;
        exp_t got;
        int   n;
        e.hi = eh; e.lo = el; e.cycles = ecyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 100) check({tag, "_timeout"}, 64'(n), 64'(ecyc));
        got = sb.pop_front();
        check({tag, "_busy_cycles"}, 64'(n), 64'(got.cycles));
        check({tag, "_hi"}, 64'(hi), 64'(got.hi));
        check({tag, "_lo"}, 64'(lo), 64'(got.lo));
        m_hi = got.hi;
        m_lo = got.lo;
    endtask

    task automatic mt(input string tag, input logic [3:0] o, input logic [W-1:0] v, input logic c);
        @(negedge clk);
        op = o; a = v; cancel = c;
        @(posedge clk); #1;
        op = NOP; cancel = 1'b0;
        if (!c) begin
            if (o == MTHI) m_hi = v;
            else m_lo = v;
        end
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [63:0] r;
        logic [3:0]  ro;
        logic [W-1:0] ra, rb;
        reset_n = 1'b0; start = 1'b0; op = NOP; a = '0; b = '0; cancel = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;

        do_op("mult", MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC);
        do_op("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MC);
        do_op("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
        mt("mthi", MTHI, 32'h11, 1'b0);
        mt("mtlo", MTLO, 32'h22, 1'b0);
        do_op("divu_by0", DIVU, 32'd7, 32'd0, 32'h11, 32'h22, DC);
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DC);
        do_op("div_7_neg2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DC);
        do_op("div_neg7_neg2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, DC);

        for (int i = 0; i < 8; i++) begin
            ro = 4'($urandom_range(0, 3));
            ra = $urandom();
            rb = (i == 5) ? '0 : W'($urandom());
            r  = model(ro, ra, rb, m_hi, m_lo);
            do_op($sformatf("rand%0d", i), ro, ra, rb, r[63:32], r[31:0], md_is_div(ro) ? DC : MC);
        end

        // Cancelled start: no issue, HI/LO untouched.
        @(negedge clk);
        start = 1'b1; op = MULT; a = 32'd3; b = 32'd4; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = NOP; cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'(0));
        repeat (MC + 1) @(posedge clk); #1;
        check("cancel_hi", 64'(hi), 64'(m_hi));
        check("cancel_lo", 64'(lo), 64'(m_lo));
        mt("mtlo_cancel", MTLO, 32'd5, 1'b1);

        // Start with a non-arithmetic op is ignored.
        @(negedge clk);
        start = 1'b1; op = NOP; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        check("badop_busy", 64'(busy), 64'(0));
`ifdef MD_ACCUMULATE_EN
        r = model(MADD, 32'hFFFF_FFFE, 32'd3, m_hi, m_lo);
        do_op("madd", MADD, 32'hFFFF_FFFE, 32'd3, r[63:32], r[31:0], MC);
`else
        @(negedge clk);
        start = 1'b1; op = MADD; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        check("madd_disabled_busy", 64'(busy), 64'(0));
`endif

        mt("mthi_pre", MTHI, 32'hAAAA_0001, 1'b0);
        mt("mtlo_pre", MTLO, 32'hBBBB_0002, 1'b0);
        @(negedge clk); op = MFHI; #1;
        check("mfhi", 64'(md_out), 64'(m_hi));
        op = MFLO; #1;
        check("mflo", 64'(md_out), 64'(m_lo));
        op = MULT; #1;
        check("mdout_other", 64'(md_out), 64'(0));
        op = NOP;

        // Reset in the third busy cycle of a divide aborts it without committing.
        @(negedge clk);
        start = 1'b1; op = DIV; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = NOP;
        check("rst_div_busy", 64'(busy), 64'(1));
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_hi", 64'(hi), 64'(0));
        check("rst_mid_lo", 64'(lo), 64'(0));
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1; op = MFLO;
        #1;
        check("rst_mflo", 64'(md_out), 64'(0));
        op = NOP;
        repeat (DC + 2) @(posedge clk); #1;
        check("rst_after_busy", 64'(busy), 64'(0));
        check("rst_after_hi", 64'(hi), 64'(0));
        check("rst_after_lo", 64'(lo), 64'(0));

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
